// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the two-master data-memory bus arbiter.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    localparam logic [1:0]  GNT_NONE  = 2'b00;
    localparam logic [1:0]  GNT_M0    = 2'b01;
    localparam logic [1:0]  GNT_M1    = 2'b10;
    localparam logic [31:0] ERR_RDATA = 32'h0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } xact_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request, completion and Dw bus signals of the arbiter. The arbiter masters the
// Dw bus through modport master; requesters and the memory sit on modport slave.
interface mem_bus_arbiter_if;

    logic        iM0Req;
    logic        iM0We;
    logic [31:0] iM0Addr;
    logic [31:0] iM0WData;
    logic [3:0]  iM0BE;
    logic        oM0Ack;
    logic        oM0Err;
    logic [31:0] oM0RData;

    logic        iM1Req;
    logic        iM1We;
    logic [31:0] iM1Addr;
    logic [31:0] iM1WData;
    logic [3:0]  iM1BE;
    logic        oM1Ack;
    logic        oM1Err;
    logic [31:0] oM1RData;

    logic [31:0] DwAddress;
    logic [31:0] DwWriteData;
    logic [3:0]  DwByteEnable;
    logic        DwWriteEnable;
    logic        DwReadEnable;
    logic [31:0] DwReadData;
    logic        iDwReady;

    logic [1:0]  oGrant;
    logic        oBusy;

    modport master (
        input  iM0Req, iM0We, iM0Addr, iM0WData, iM0BE,
        output oM0Ack, oM0Err, oM0RData,
        input  iM1Req, iM1We, iM1Addr, iM1WData, iM1BE,
        output oM1Ack, oM1Err, oM1RData,
        output DwAddress, DwWriteData, DwByteEnable, DwWriteEnable, DwReadEnable,
        input  DwReadData, iDwReady,
        output oGrant, oBusy
    );

    modport slave (
        output iM0Req, iM0We, iM0Addr, iM0WData, iM0BE,
        input  oM0Ack, oM0Err, oM0RData,
        output iM1Req, iM1We, iM1Addr, iM1WData, iM1BE,
        input  oM1Ack, oM1Err, oM1RData,
        input  DwAddress, DwWriteData, DwByteEnable, DwWriteEnable, DwReadEnable,
        output DwReadData, iDwReady,
        input  oGrant, oBusy
    );

endinterface

// File: rtl/arb_starve_sel.sv
// Winner select between M0 and M1 with a starvation counter that lets M1 through
// after STARVE_LIMIT consecutive losses. The counter only moves on IDLE cycles.
module arb_starve_sel
    import mem_bus_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       idle_i,
    output logic [1:0] winner_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 2);

    logic [SW-1:0] starve_q, starve_d;
    logic          m1_wins;

    always_comb begin
        m1_wins  = req1_i && (!req0_i || (starve_q == SW'(STARVE_LIMIT)));
        winner_o = GNT_NONE;
        if (m1_wins) begin
            winner_o = GNT_M1;
        end else if (req0_i) begin
            winner_o = GNT_M0;
        end

        starve_d = starve_q;
        if (idle_i) begin
            if (!req1_i || m1_wins) begin
                starve_d = '0;
            end else if (starve_q != SW'(STARVE_LIMIT)) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master sequencer for the core's data-memory bus: latch one request, run it
// on the Dw bus until ready or timeout, then pulse the owner's Ack for one cycle.
//   state   | meaning
//   ST_IDLE | no owner, arbitrating incoming requests
//   ST_XFER | Dw strobes driven from the transaction register, waiting for ready
//   ST_ACK  | owner's Ack/Err/RData valid, strobes low, turnaround to IDLE
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 15
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    mem_bus_arbiter_if.master bus
);

    localparam int WW = $clog2(MAX_WAIT + 2);

    arb_state_e    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    xact_t         xact_q, xact_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
    logic          err_q, err_d;
    logic [1:0]    winner;
    logic          done_rd, done_to;
    logic [31:0]   cap_data;
    logic          in_xfer, ack0, ack1;

    arb_starve_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_sel (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .req0_i   (bus.iM0Req),
        .req1_i   (bus.iM1Req),
        .idle_i   (state_q == ST_IDLE),
        .winner_o (winner)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        xact_d   = xact_q;
        wait_d   = wait_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err_d    = err_q;

        // Ready in the final wait cycle still counts as a normal completion.
        done_rd  = (state_q == ST_XFER) && bus.iDwReady;
        done_to  = (state_q == ST_XFER) && !bus.iDwReady && (wait_q == WW'(MAX_WAIT));
        cap_data = done_rd ? (xact_q.we ? 32'h0 : bus.DwReadData) : ERR_RDATA;

        case (state_q)
            ST_IDLE: begin
                if (winner != GNT_NONE) begin
                    state_d = ST_XFER;
                    grant_d = winner;
                    wait_d  = '0;
                    if (winner[1]) begin
                        xact_d.we    = bus.iM1We;
                        xact_d.addr  = bus.iM1Addr;
                        xact_d.wdata = bus.iM1WData;
                        xact_d.be    = bus.iM1BE;
                    end else begin
                        xact_d.we    = bus.iM0We;
                        xact_d.addr  = bus.iM0Addr;
                        xact_d.wdata = bus.iM0WData;
                        xact_d.be    = bus.iM0BE;
                    end
                end
            end
            ST_XFER: begin
                wait_d = wait_q + WW'(1);
                if (done_rd || done_to) begin
                    state_d = ST_ACK;
                    err_d   = done_to;
                    if (grant_q[1]) begin
                        rdata1_d = cap_data;
                    end else begin
                        rdata0_d = cap_data;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= ST_IDLE;
            grant_q  <= GNT_NONE;
            xact_q   <= '0;
            wait_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            xact_q   <= xact_d;
            wait_q   <= wait_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err_q    <= err_d;
        end
    end

    assign in_xfer = (state_q == ST_XFER);
    assign ack0    = (state_q == ST_ACK) && grant_q[0];
    assign ack1    = (state_q == ST_ACK) && grant_q[1];

    assign bus.DwAddress     = xact_q.addr;
    assign bus.DwWriteData   = xact_q.wdata;
    assign bus.DwByteEnable  = xact_q.be;
    assign bus.DwWriteEnable = in_xfer && xact_q.we;
    assign bus.DwReadEnable  = in_xfer && !xact_q.we;

    assign bus.oM0Ack   = ack0;
    assign bus.oM0Err   = ack0 && err_q;
    assign bus.oM0RData = rdata0_q;
    assign bus.oM1Ack   = ack1;
    assign bus.oM1Err   = ack1 && err_q;
    assign bus.oM1RData = rdata1_q;

    assign bus.oGrant = grant_q;
    assign bus.oBusy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then randomized traffic, checked
// against a transaction-level model of arbitration, latency, timeout and read data.
module tb_mem_bus_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_WAIT     = 15;

    logic iCLK;
    logic iRST_N;

    mem_bus_arbiter_if bus ();

    int          n_checks = 0;
    int          n_errs   = 0;
    int          starve_m;
    logic [31:0] rdata_m [2];
    logic [1:0]  exp_seq [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

    mem_bus_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_WAIT     (MAX_WAIT)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ack0"},  32'(bus.oM0Ack), 32'd0);
        check_val({tag, "_err0"},  32'(bus.oM0Err), 32'd0);
        check_val({tag, "_rd0"},   bus.oM0RData, 32'd0);
        check_val({tag, "_ack1"},  32'(bus.oM1Ack), 32'd0);
        check_val({tag, "_err1"},  32'(bus.oM1Err), 32'd0);
        check_val({tag, "_rd1"},   bus.oM1RData, 32'd0);
        check_val({tag, "_addr"},  bus.DwAddress, 32'd0);
        check_val({tag, "_wdata"}, bus.DwWriteData, 32'd0);
        check_val({tag, "_be"},    32'(bus.DwByteEnable), 32'd0);
        check_val({tag, "_we"},    32'(bus.DwWriteEnable), 32'd0);
        check_val({tag, "_re"},    32'(bus.DwReadEnable), 32'd0);
        check_val({tag, "_gnt"},   32'(bus.oGrant), 32'd0);
        check_val({tag, "_busy"},  32'(bus.oBusy), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, 32'(bus.oBusy), 32'd0);
        check_val({tag, "_gnt"},  32'(bus.oGrant), 32'd0);
        check_val({tag, "_we"},   32'(bus.DwWriteEnable), 32'd0);
        check_val({tag, "_re"},   32'(bus.DwReadEnable), 32'd0);
        check_val({tag, "_ack0"}, 32'(bus.oM0Ack), 32'd0);
        check_val({tag, "_ack1"}, 32'(bus.oM1Ack), 32'd0);
        check_val({tag, "_rd0"},  bus.oM0RData, rdata_m[0]);
        check_val({tag, "_rd1"},  bus.oM1RData, rdata_m[1]);
    endtask

    task automatic rand_fields();
        bus.iM0We    = 1'($urandom_range(0, 1));
        bus.iM0Addr  = $urandom;
        bus.iM0WData = $urandom;
        bus.iM0BE    = 4'($urandom);
        bus.iM1We    = 1'($urandom_range(0, 1));
        bus.iM1Addr  = $urandom;
        bus.iM1WData = $urandom;
        bus.iM1BE    = 4'($urandom);
    endtask

    // Called in an IDLE cycle. w = wait states the slave inserts before ready
    // (w > MAX_WAIT means the slave never answers). Returns strobe cycles seen
    // and the grant observed in the first XFER cycle.
    task automatic run_slot(input logic r0, input logic r1, input int w, input logic [31:0] rd,
                            input logic drop_ok, output int n_str, output logic [1:0] obs_gnt);
        int          win;
        int          len;
        logic        we;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        n_str   = 0;
        obs_gnt = 2'b00;
        check_idle("idle");
        bus.iM0Req = r0;
        bus.iM1Req = r1;
        if (!r0 && !r1) begin
            starve_m = 0;
            @(posedge iCLK); #1;
        end else begin
            win = (r1 && (!r0 || starve_m == STARVE_LIMIT)) ? 1 : 0;
            if (!r1 || win == 1) starve_m = 0;
            else if (starve_m < STARVE_LIMIT) starve_m++;
            if (win == 1) {we, addr, wdata, be} = {bus.iM1We, bus.iM1Addr, bus.iM1WData, bus.iM1BE};
            else          {we, addr, wdata, be} = {bus.iM0We, bus.iM0Addr, bus.iM0WData, bus.iM0BE};
            len    = ((w < MAX_WAIT) ? w : MAX_WAIT) + 1;
            err    = (w > MAX_WAIT);
            exp_rd = (err || we) ? 32'h0 : rd;
            @(posedge iCLK); #1;
            obs_gnt = bus.oGrant;
            check_val("grant", 32'(bus.oGrant), (win == 1) ? 32'd2 : 32'd1);
            for (int k = 0; k < len; k++) begin
                check_val("xfer_busy", 32'(bus.oBusy), 32'd1);
                check_val("xfer_we",   32'(bus.DwWriteEnable), 32'(we));
                check_val("xfer_re",   32'(bus.DwReadEnable), 32'(!we));
                check_val("xfer_addr", bus.DwAddress, addr);
                check_val("xfer_wdat", bus.DwWriteData, wdata);
                check_val("xfer_be",   32'(bus.DwByteEnable), 32'(be));
                check_val("xfer_ack0", 32'(bus.oM0Ack), 32'd0);
                check_val("xfer_ack1", 32'(bus.oM1Ack), 32'd0);
                n_str += int'(bus.DwWriteEnable | bus.DwReadEnable);
                rand_fields();
                if (drop_ok && $urandom_range(0, 3) == 0) begin
                    if (win == 1) bus.iM1Req = 1'b0;
                    else          bus.iM0Req = 1'b0;
                end
                bus.iDwReady   = (k == w);
                bus.DwReadData = (k == w) ? rd : $urandom;
                @(posedge iCLK); #1;
            end
            bus.iDwReady = 1'b0;
            rdata_m[win] = exp_rd;
            check_val("ack_owner", 32'((win == 1) ? bus.oM1Ack : bus.oM0Ack), 32'd1);
            check_val("ack_other", 32'((win == 1) ? bus.oM0Ack : bus.oM1Ack), 32'd0);
            check_val("ack_err",   32'((win == 1) ? bus.oM1Err : bus.oM0Err), 32'(err));
            check_val("ack_rd0",   bus.oM0RData, rdata_m[0]);
            check_val("ack_rd1",   bus.oM1RData, rdata_m[1]);
            check_val("ack_we",    32'(bus.DwWriteEnable), 32'd0);
            check_val("ack_re",    32'(bus.DwReadEnable), 32'd0);
            bus.iM0Req = 1'b0;
            bus.iM1Req = 1'b0;
            @(posedge iCLK); #1;
        end
    endtask

    initial begin
        int         n;
        logic [1:0] g;
        logic       r0;
        logic       r1;
        int         w;

        iRST_N         = 1'b1;
        bus.iM0Req     = 1'b0;
        bus.iM1Req     = 1'b0;
        bus.iDwReady   = 1'b0;
        bus.DwReadData = 32'h0;
        rand_fields();
        #1 iRST_N = 1'b0;
        #1 check_zero("rst_async");
        repeat (2) @(posedge iCLK);
        @(negedge iCLK) iRST_N = 1'b1;
        starve_m   = 0;
        rdata_m[0] = 32'h0;
        rdata_m[1] = 32'h0;
        @(posedge iCLK); #1;
        check_zero("rst_state");

        // M0 read, ready immediately
        rand_fields();
        bus.iM0We   = 1'b0;
        bus.iM0Addr = 32'h1000_0040;
        run_slot(1'b1, 1'b0, 0, 32'hCAFE_0001, 1'b0, n, g);
        check_val("t1_rdata", bus.oM0RData, 32'hCAFE_0001);
        check_val("t1_rd_cycles", 32'(n), 32'd1);

        // M1 write with 3 wait states
        rand_fields();
        bus.iM1We    = 1'b1;
        bus.iM1Addr  = 32'h0000_2000;
        bus.iM1WData = 32'hA5A5_A5A5;
        bus.iM1BE    = 4'b0011;
        run_slot(1'b0, 1'b1, 3, $urandom, 1'b0, n, g);
        check_val("t2_wr_cycles", 32'(n), 32'd4);
        check_val("t2_rdata", bus.oM1RData, 32'h0);

        // Both masters requesting continuously
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            run_slot(1'b1, 1'b1, 0, $urandom, 1'b0, n, g);
            check_val("t3_gnt_seq", 32'(g), 32'(exp_seq[i]));
        end

        // Slave never ready, then a normal transaction
        rand_fields();
        bus.iM0We = 1'b0;
        run_slot(1'b1, 1'b0, MAX_WAIT + 5, $urandom, 1'b0, n, g);
        check_val("t4_xfer_cycles", 32'(n), 32'(MAX_WAIT + 1));
        check_val("t4_rdata", bus.oM0RData, 32'h0);
        rand_fields();
        bus.iM0We = 1'b0;
        run_slot(1'b1, 1'b0, 1, 32'h0BAD_F00D, 1'b0, n, g);
        check_val("t4_next_rdata", bus.oM0RData, 32'h0BAD_F00D);

        // Reset in the middle of XFER after 2 wait states
        rand_fields();
        bus.iM0We  = 1'b0;
        bus.iM0Req = 1'b1;
        bus.iM1Req = 1'b0;
        @(posedge iCLK); #1;
        check_val("t5_busy", 32'(bus.oBusy), 32'd1);
        repeat (2) begin
            @(posedge iCLK); #1;
        end
        check_val("t5_re_before", 32'(bus.DwReadEnable), 32'd1);
        #1 iRST_N = 1'b0;
        #1 check_zero("t5_rst");
        @(posedge iCLK); #1;
        check_zero("t5_hold");
        bus.iM0Req = 1'b0;
        @(negedge iCLK) iRST_N = 1'b1;
        starve_m   = 0;
        rdata_m[0] = 32'h0;
        rdata_m[1] = 32'h0;
        @(posedge iCLK); #1;
        rand_fields();
        bus.iM1We = 1'b0;
        run_slot(1'b0, 1'b1, 0, 32'h5150_0001, 1'b0, n, g);
        check_val("t5_m1_rdata", bus.oM1RData, 32'h5150_0001);

        // Ready coincides with the timeout cycle
        rand_fields();
        bus.iM0We = 1'b0;
        run_slot(1'b1, 1'b0, MAX_WAIT, 32'h1234_5678, 1'b0, n, g);
        check_val("t6_xfer_cycles", 32'(n), 32'(MAX_WAIT + 1));
        check_val("t6_rdata", bus.oM0RData, 32'h1234_5678);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            rand_fields();
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) != 0) begin
                r0 = 1'b1;
                r1 = 1'($urandom_range(0, 3) != 0);
            end
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAX_WAIT - 2, MAX_WAIT + 3))
                                            : int'($urandom_range(0, 3));
            run_slot(r0, r1, w, $urandom, 1'b1, n, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter and transaction sequencer for the single data-memory bus (`Dw*` signals) of the multicycle RISC-V core. Master 0 is the CPU datapath and master 1 is a secondary requester such as DMA, a VGA fetcher or a debug port. The block latches one request at a time, drives the bus, and waits for slave ready. It then returns read data with a one-cycle acknowledge, and times out stalled slaves.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive lost arbitrations after which M1 wins over M0.
- `MAX_WAIT`, 15: maximum cycles in XFER before a timeout error.

Ports:
- `iCLK` in 1: system clock. All state updates on the rising edge.
- `iRST_N` in 1: reset, asynchronous, active-low.
- `iM0Req` in 1: M0 request. Held high until `oM0Ack`.
- `iM0We` in 1: M0 write (1) or read (0).
- `iM0Addr` in 32: M0 address.
- `iM0WData` in 32: M0 write data.
- `iM0BE` in 4: M0 byte enables.
- `oM0Ack` out 1: one-cycle completion pulse to M0.
- `oM0Err` out 1: timeout flag, valid with `oM0Ack`.
- `oM0RData` out 32: read data to M0, valid with `oM0Ack`.
- `iM1Req`, `iM1We`, `iM1Addr`, `iM1WData`, `iM1BE`, `oM1Ack`, `oM1Err`, `oM1RData`: same as the M0 ports, for M1.
- `DwAddress` out 32: bus address.
- `DwWriteData` out 32: bus write data.
- `DwByteEnable` out 4: bus byte enables.
- `DwWriteEnable` out 1: bus write strobe.
- `DwReadEnable` out 1: bus read strobe.
- `DwReadData` in 32: slave read data.
- `iDwReady` in 1: slave completes the current access this cycle.
- `oGrant` out 2: one-hot owner (bit0 = M0, bit1 = M1). 0 when idle.
- `oBusy` out 1: high in XFER or ACK.

## Operation
State machine states: IDLE, XFER, ACK.

IDLE
- If any request is high, select a winner.
- Latch the winner's We, Addr, WData and BE into the transaction register.
- Set `oGrant` and go to XFER. Otherwise stay in IDLE.

Arbitration
- M0 wins by default.
- M1 wins if only M1 requests, or if both request and the starve counter equals `STARVE_LIMIT`.
- Starve counter:
  - Increments (saturating) when both request and M0 wins.
  - Clears when M1 is granted or when `iM1Req` is low in IDLE.

XFER
- Drive `Dw*` from the transaction register.
- `DwWriteEnable` = We. `DwReadEnable` = ~We.
- The wait counter increments each cycle.
- On `iDwReady`:
  - Capture `DwReadData` into the owner's RData. Writes capture 0.
  - Go to ACK.
- Timeout: if the wait counter reaches `MAX_WAIT` without ready, load RData = 32'h0, set Err, go to ACK.
- If ready and the timeout coincide, ready wins and Err stays 0.

ACK
- Pulse the owner's Ack, with Err and RData valid.
- Deassert all `Dw*` strobes. `DwAddress`, `DwWriteData` and `DwByteEnable` may hold their values.
- Clear `oGrant` and go to IDLE.
- This one turnaround cycle means there are no back-to-back grants.

Request fields are sampled only in IDLE. Changes while the master is waiting are ignored.

A request dropped by a master before its Ack is not cancelled. The transaction completes and the Ack is still issued.

RData outputs hold their last value between Acks.

## Timing
- Reset (asynchronous, on `iRST_N` low) drives every output to 0: all Acks, Errs, RData, `Dw*`, `oGrant`, `oBusy`. State goes to IDLE and both counters clear. An in-flight transaction is abandoned and no Ack is issued.
- Minimum latency: request sampled in IDLE at edge N, XFER in cycle N+1 with `iDwReady` = 1, Ack high in cycle N+2. That is 2 cycles from request to Ack.
- Each wait state adds 1 cycle.
- Timeout Ack arrives at cycle N+2+`MAX_WAIT`.
- `Dw*` strobes are high only in XFER cycles.
- Throughput: one transaction per 3 cycles minimum.

## Structure
- Shared package `mem_bus_arb_pkg` holds:
  - the state enum (IDLE, XFER, ACK);
  - the one-hot grant constants `GNT_NONE`, `GNT_M0`, `GNT_M1`;
  - the timeout read value `ERR_RDATA` = 32'h0.
- One sub-module, `arb_starve_sel`: starve counter plus winner select. Inputs: both requests and an IDLE strobe. Outputs: the one-hot winner.
- The top level contains the FSM, transaction register, wait counter and output muxing.

## Test plan
- M0 read of 0x1000_0040, slave ready immediately, `DwReadData` = 0xCAFE_0001 -> `oM0Ack` 2 cycles after the request with `oM0RData` = 0xCAFE_0001; `DwReadEnable` high for exactly 1 cycle.
- M1 write of 0xA5A5_A5A5 to 0x2000, BE = 4'b0011, 3 wait states -> `DwWriteEnable` high for 4 cycles with `DwByteEnable` = 4'b0011; `oM1Ack` at cycle 5 with `oM1Err` = 0.
- Both masters request continuously -> grant sequence M0,M0,M0,M0,M1,M0,M0,M0,M0,M1 with `STARVE_LIMIT` = 4.
- Slave never ready -> `oM0Ack` at cycle 2+15 with `oM0Err` = 1 and `oM0RData` = 0; the next request proceeds normally.
- `iRST_N` pulsed low during XFER with 2 wait states elapsed -> all outputs 0 immediately, no Ack issued; after release a new M1 request completes in 2 cycles.
- Ready asserted in the same cycle the timeout would fire -> Ack with Err = 0 and RData = `DwReadData`.
